// File: rtl/elapsed_time_meter.sv
// Start/stop interval meter: counts clock cycles and reports floor(N * PERIOD_PS / 1000) ns.
// Optional auto-stop on a ns threshold when TIME_METER_TIMEOUT_EN is defined.
`timescale 1ns / 1ps

module elapsed_time_meter #(
    parameter int unsigned FREQ_KHZ   = 100000,
    parameter int unsigned RESULT_W   = 32
`ifdef TIME_METER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_NS = 1000000
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                stop_i,
    output logic                busy_o,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [RESULT_W-1:0] result_ns_o,
    output logic                overflow_o
`ifdef TIME_METER_TIMEOUT_EN
    ,
    output logic                timeout_o
`endif
);

    localparam int unsigned PERIOD_PS  = 1000000000 / FREQ_KHZ;
    localparam int unsigned NS_PER_CLK = PERIOD_PS / 1000;
    localparam int unsigned PS_REM     = PERIOD_PS % 1000;

    localparam logic [RESULT_W:0] NS_STEP = (RESULT_W + 1)'(NS_PER_CLK);
    localparam logic [RESULT_W:0] NS_MAX  = {1'b0, {RESULT_W{1'b1}}};

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [9:0]        ps_acc_q;
    logic [RESULT_W:0] ns_acc_q;
    logic              ovf_q;

    logic [10:0]       ps_sum;
    logic              ps_carry;
    logic [9:0]        ps_acc_d;
    logic [RESULT_W:0] ns_sum;
    logic [RESULT_W:0] ns_acc_d;
    logic              ovf_d;
    logic              end_run;

    // Sub-ns remainder is carried in ps so the ns total never drifts.
    always_comb begin
        ps_sum   = {1'b0, ps_acc_q} + 11'(PS_REM);
        ps_carry = (ps_sum >= 11'd1000);
        ps_acc_d = ps_carry ? 10'(ps_sum - 11'd1000) : ps_sum[9:0];
        ns_sum   = ns_acc_q + NS_STEP + {{RESULT_W{1'b0}}, ps_carry};
        if (ns_sum > NS_MAX) begin
            ns_acc_d = NS_MAX;
            ovf_d    = 1'b1;
        end else begin
            ns_acc_d = ns_sum;
            ovf_d    = ovf_q;
        end
    end

`ifdef TIME_METER_TIMEOUT_EN
    // A threshold beyond the saturated range can never be reached.
    localparam logic [RESULT_W:0] TIMEOUT_V = (64'(TIMEOUT_NS) > 64'(NS_MAX)) ?
        {1'b1, {RESULT_W{1'b0}}} : (RESULT_W + 1)'(TIMEOUT_NS);
    logic tmo_hit;
    assign tmo_hit = (ns_acc_d >= TIMEOUT_V);
    assign end_run = stop_i | tmo_hit;
`else
    assign end_run = stop_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            ps_acc_q       <= '0;
            ns_acc_q       <= '0;
            ovf_q          <= 1'b0;
            busy_o         <= 1'b0;
            result_valid_o <= 1'b0;
            result_ns_o    <= '0;
            overflow_o     <= 1'b0;
`ifdef TIME_METER_TIMEOUT_EN
            timeout_o      <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q  <= StRun;
                        busy_o   <= 1'b1;
                        ps_acc_q <= '0;
                        ns_acc_q <= '0;
                        ovf_q    <= 1'b0;
                    end
                end
                StRun: begin
                    if (start_i) begin
                        ps_acc_q <= '0;
                        ns_acc_q <= '0;
                        ovf_q    <= 1'b0;
                    end else begin
                        ps_acc_q <= ps_acc_d;
                        ns_acc_q <= ns_acc_d;
                        ovf_q    <= ovf_d;
                        if (end_run) begin
                            state_q        <= StDone;
                            busy_o         <= 1'b0;
                            result_valid_o <= 1'b1;
                            result_ns_o    <= ns_acc_d[RESULT_W-1:0];
                            overflow_o     <= ovf_d;
`ifdef TIME_METER_TIMEOUT_EN
                            timeout_o      <= ~stop_i;
`endif
                        end
                    end
                end
                StDone: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
`ifdef TIME_METER_TIMEOUT_EN
                        timeout_o      <= 1'b0;
`endif
                        if (start_i) begin
                            state_q  <= StRun;
                            busy_o   <= 1'b1;
                            ps_acc_q <= '0;
                            ns_acc_q <= '0;
                            ovf_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
